// File: rtl/pio_debounce_irq_if.sv
// Avalon-MM slave bus of the debounced PIO together with its interrupt line to the CPU.
interface pio_debounce_irq_if;
  logic        chipselect;
  logic [2:0]  address;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output chipselect, address, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  chipselect, address, write_n, writedata,
    output readdata, irq
  );
endinterface

// File: rtl/pio_debounce_irq.sv
// WIDTH-channel debounced input PIO: two-flop synchroniser, run-time programmable counter
// debounce, per-channel rise/fall edge select, write-1-to-clear edge capture and masked IRQ.
module pio_debounce_irq #(
  parameter int                    WIDTH      = 2,
  parameter int                    CNT_W      = 16,
  parameter logic [CNT_W-1:0]      DEB_RESET  = CNT_W'(50000),
  parameter logic [WIDTH-1:0]      INIT_LEVEL = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0]      RISE_RESET = {WIDTH{1'b0}},
  parameter logic [WIDTH-1:0]      FALL_RESET = {WIDTH{1'b1}}
) (
  input  logic                  clk,
  input  logic                  reset_n,
  pio_debounce_irq_if.slave     bus,
  input  logic [WIDTH-1:0]      in_port
);

  typedef enum logic [2:0] {
    A_DATA  = 3'd0,
    A_RAW   = 3'd1,
    A_MASK  = 3'd2,
    A_CAPT  = 3'd3,
    A_RISE  = 3'd4,
    A_FALL  = 3'd5,
    A_LIMIT = 3'd6,
    A_NONE  = 3'd7
  } reg_addr_e;

  logic [WIDTH-1:0] sync1, sync2;
  logic [WIDTH-1:0] db, dbq;
  logic [CNT_W-1:0] cnt [WIDTH];

  logic [WIDTH-1:0] irq_mask, edge_cap, rise_en, fall_en;
  logic [CNT_W-1:0] deb_limit;
  logic [31:0]      readdata_q, rd_next;

  logic             wr;
  reg_addr_e        addr;
  logic [WIDTH-1:0] ev, clr_mask;

  // Only the low WIDTH/CNT_W bits of writedata are meaningful; the rest are deliberately dropped.
  logic unused_wdata;
  assign unused_wdata = ^bus.writedata;

  assign wr   = bus.chipselect & ~bus.write_n;
  assign addr = reg_addr_e'(bus.address);

  // Synchroniser and debounce. A channel's counter measures how long the synchronised
  // input has disagreed with the debounced level; once it reaches the limit, db follows.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= INIT_LEVEL;
      sync2 <= INIT_LEVEL;
      db    <= INIT_LEVEL;
      dbq   <= INIT_LEVEL;
      // NOTE: the counters are a handful of flops, not a RAM, so resetting them is cheap and required.
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values, like real hardware.
      sync1 <= in_port;
      sync2 <= sync1;
      dbq   <= db;
      for (int i = 0; i < WIDTH; i++) begin
        if (sync2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] >= deb_limit) begin
          db[i]  <= sync2[i];
          cnt[i] <= '0;
        end else if (cnt[i] != {CNT_W{1'b1}}) begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign ev       = (db & ~dbq & rise_en) | (~db & dbq & fall_en);
  assign clr_mask = (wr && addr == A_CAPT) ? bus.writedata[WIDTH-1:0] : '0;

  // Read mux: registered every cycle regardless of chipselect.
  always_comb begin
    // NOTE: default first so no path through the case leaves rd_next unassigned (no latch).
    rd_next = '0;
    unique case (addr)
      A_DATA:  rd_next[WIDTH-1:0] = db;
      A_RAW:   rd_next[WIDTH-1:0] = sync2;
      A_MASK:  rd_next[WIDTH-1:0] = irq_mask;
      A_CAPT:  rd_next[WIDTH-1:0] = edge_cap;
      A_RISE:  rd_next[WIDTH-1:0] = rise_en;
      A_FALL:  rd_next[WIDTH-1:0] = fall_en;
      A_LIMIT: rd_next[CNT_W-1:0] = deb_limit;
      A_NONE:  rd_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask   <= '0;
      edge_cap   <= '0;
      rise_en    <= RISE_RESET;
      fall_en    <= FALL_RESET;
      deb_limit  <= DEB_RESET;
      readdata_q <= '0;
    end else begin
      readdata_q <= rd_next;
      // A new event wins over a same-cycle clear so it is never lost.
      edge_cap   <= (edge_cap & ~clr_mask) | ev;
      if (wr) begin
        case (addr)
          A_MASK:  irq_mask  <= bus.writedata[WIDTH-1:0];
          A_RISE:  rise_en   <= bus.writedata[WIDTH-1:0];
          A_FALL:  fall_en   <= bus.writedata[WIDTH-1:0];
          A_LIMIT: deb_limit <= bus.writedata[CNT_W-1:0];
          default: ;
        endcase
      end
    end
  end

  assign bus.readdata = readdata_q;
  assign bus.irq      = |(edge_cap & irq_mask);

endmodule

// File: tb/tb_pio_debounce_irq.sv
// Self-checking bench for pio_debounce_irq: reset/read table, directed debounce/edge/race
// sequences and a randomized run against a window-based reference model.
module tb_pio_debounce_irq;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] in_port = 2'b11;

  pio_debounce_irq_if bus ();

  pio_debounce_irq #(
    .WIDTH     (2),
    .CNT_W     (16),
    .DEB_RESET (16'd4)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .in_port (in_port)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [2:0]  addr;
    logic [31:0] exp;
  } rd_vec_t;

  rd_vec_t reset_tab [8];

  // Reference model state for the randomized run.
  localparam int HN = 4096;
  logic [1:0]  hist [HN];
  int          t;
  int          lc [2];
  int          m_lim;
  logic [1:0]  m_db, m_dbq, m_cap, m_mask, m_rise, m_fall;
  logic [31:0] m_rd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.address    = 3'd0;
    bus.writedata  = 32'd0;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.address    = a;
    bus.writedata  = d;
    tick();
    bus_idle();
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.address    = a;
    tick();
    d = bus.readdata;
    bus.address = 3'd0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    bus_idle();
    in_port = 2'b11;
    repeat (3) tick();
    reset_n = 1'b1;
  endtask

  task automatic check_reset_table(input string tag);
    logic [31:0] d;
    for (int i = 0; i < 8; i++) begin
      bus_read(reset_tab[i].addr, d);
      check($sformatf("%s_addr%0d", tag, reset_tab[i].addr), d, reset_tab[i].exp);
    end
  endtask

  // One clock edge of the reference model. Debounce is expressed as a window rule:
  // db flips at edge t when the synchronised input seen at the last DEB_LIMIT+1 edges
  // (all after the previous flip) disagreed with db.
  task automatic model_edge(input logic cs, input logic [2:0] a, input logic wn,
                            input logic [31:0] wd, input logic [1:0] inp);
    logic [1:0]  db_n, ev, clr;
    logic        wr, all_diff;
    logic [31:0] rd;
    hist[t] = inp;
    db_n = m_db;
    for (int ch = 0; ch < 2; ch++) begin
      all_diff = (t - lc[ch]) >= (m_lim + 1);
      for (int j = 0; j <= m_lim; j++)
        if (hist[t-2-j][ch] == m_db[ch]) all_diff = 1'b0;
      if (all_diff) begin
        db_n[ch] = ~m_db[ch];
        lc[ch]   = t;
      end
    end
    ev = (m_db & ~m_dbq & m_rise) | (~m_db & m_dbq & m_fall);
    rd = 32'd0;
    case (a)
      3'd0: rd[1:0] = m_db;
      3'd1: rd[1:0] = hist[t-2];
      3'd2: rd[1:0] = m_mask;
      3'd3: rd[1:0] = m_cap;
      3'd4: rd[1:0] = m_rise;
      3'd5: rd[1:0] = m_fall;
      3'd6: rd      = 32'(m_lim);
      default: rd   = 32'd0;
    endcase
    wr  = cs & ~wn;
    clr = (wr && a == 3'd3) ? wd[1:0] : 2'b00;
    m_cap = (m_cap & ~clr) | ev;
    if (wr && a == 3'd2) m_mask = wd[1:0];
    if (wr && a == 3'd4) m_rise = wd[1:0];
    if (wr && a == 3'd5) m_fall = wd[1:0];
    m_dbq = m_db;
    m_db  = db_n;
    m_rd  = rd;
    t++;
  endtask

  initial begin
    logic [31:0] d;
    logic [1:0]  cur;
    logic        cs, wn;
    logic [2:0]  a;
    logic [31:0] wd;
    int          r;

    reset_tab[0] = '{3'd0, 32'd3};
    reset_tab[1] = '{3'd1, 32'd3};
    reset_tab[2] = '{3'd2, 32'd0};
    reset_tab[3] = '{3'd3, 32'd0};
    reset_tab[4] = '{3'd4, 32'd0};
    reset_tab[5] = '{3'd5, 32'd3};
    reset_tab[6] = '{3'd6, 32'd4};
    reset_tab[7] = '{3'd7, 32'd0};

    // Reset state and register reads.
    bus_idle();
    #2;
    check("rst_readdata", bus.readdata, 32'd0);
    check("rst_irq", {31'd0, bus.irq}, 32'd0);
    do_reset();
    check_reset_table("reset");

    // 4-cycle glitch on channel 0 must not reach DATA or the capture register.
    do_reset();
    bus_write(3'd2, 32'd1);
    in_port = 2'b10;
    repeat (4) tick();
    in_port = 2'b11;
    repeat (12) tick();
    bus_read(3'd0, d);
    check("glitch_data", d, 32'd3);
    bus_read(3'd3, d);
    check("glitch_capt", d, 32'd0);
    check("glitch_irq", {31'd0, bus.irq}, 32'd0);

    // Held fall on channel 0: db at k+6, seen on readdata and irq after k+7.
    in_port = 2'b10;
    for (int n = 1; n <= 8; n++) begin
      tick();
      if (n == 7) begin
        check("fall_data_k6", bus.readdata, 32'd3);
        check("fall_irq_k6", {31'd0, bus.irq}, 32'd0);
      end
      if (n == 8) begin
        check("fall_data_k7", bus.readdata, 32'd2);
        check("fall_irq_k7", {31'd0, bus.irq}, 32'd1);
      end
    end
    bus_read(3'd3, d);
    check("fall_capt", d, 32'd1);

    // Edge select: rise only on channel 1.
    do_reset();
    bus_write(3'd4, 32'd2);
    bus_write(3'd5, 32'd0);
    in_port = 2'b01;
    repeat (10) tick();
    bus_read(3'd0, d);
    check("es_data_low", d, 32'd1);
    bus_read(3'd3, d);
    check("es_no_fall_capt", d, 32'd0);
    in_port = 2'b11;
    repeat (10) tick();
    bus_read(3'd3, d);
    check("es_rise_capt", d, 32'd2);
    check("es_irq_masked", {31'd0, bus.irq}, 32'd0);

    // W1C of both bits on the same edge that ev[0] sets bit 0.
    bus_write(3'd5, 32'd3);
    in_port = 2'b10;
    repeat (7) tick();
    bus_write(3'd3, 32'd3);
    bus_read(3'd3, d);
    check("w1c_race", d, 32'd1);

    // Limit lowered mid-count: write lands on edge k+4 (cnt becomes 3), db flips at k+5.
    do_reset();
    in_port = 2'b10;
    repeat (4) tick();
    bus_write(3'd6, 32'd1);
    tick();
    check("lim_data_k5", bus.readdata, 32'd3);
    tick();
    check("lim_data_k6", bus.readdata, 32'd2);
    bus_write(3'd6, 32'd0);
    in_port = 2'b11;
    repeat (3) tick();
    check("lim0_data_m2", bus.readdata, 32'd2);
    tick();
    check("lim0_data_m3", bus.readdata, 32'd3);

    // Asynchronous reset in the middle of a count with a capture pending.
    bus_write(3'd2, 32'd1);
    bus_write(3'd6, 32'd7);
    check("pre_rst_irq", {31'd0, bus.irq}, 32'd1);
    in_port = 2'b10;
    repeat (4) tick();
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_irq", {31'd0, bus.irq}, 32'd0);
    check("async_rst_readdata", bus.readdata, 32'd0);
    in_port = 2'b11;
    repeat (2) tick();
    reset_n = 1'b1;
    check_reset_table("midrst");

    // Randomized run against the reference model.
    do_reset();
    bus_write(3'd6, 32'd3);
    bus_write(3'd4, 32'd1);
    bus_write(3'd5, 32'd3);
    bus_write(3'd2, 32'd3);
    m_lim = 3; m_rise = 2'b01; m_fall = 2'b11; m_mask = 2'b11;
    m_cap = 2'b00; m_db = 2'b11; m_dbq = 2'b11; m_rd = 32'd0;
    for (int i = 0; i < 16; i++) hist[i] = 2'b11;
    t = 16;
    lc[0] = -100;
    lc[1] = -100;
    cur = 2'b11;
    for (int n = 0; n < 1500; n++) begin
      for (int ch = 0; ch < 2; ch++)
        if ($urandom_range(0, 4) == 0) cur[ch] = ~cur[ch];
      r  = $urandom_range(0, 15);
      cs = 1'($urandom_range(0, 1));
      wn = 1'b1;
      a  = 3'($urandom_range(0, 7));
      wd = $urandom;
      if (r < 2) begin
        cs = 1'b1; wn = 1'b0; a = 3'd3;
      end else if (r == 2) begin
        cs = 1'b1; wn = 1'b0;
        if (a == 3'd6) a = 3'd2;
      end else if (r == 3) begin
        cs = 1'b0; wn = 1'b0;
      end
      bus.chipselect = cs;
      bus.write_n    = wn;
      bus.address    = a;
      bus.writedata  = wd;
      in_port        = cur;
      tick();
      model_edge(cs, a, wn, wd, cur);
      check($sformatf("rand_readdata_%0d", n), bus.readdata, m_rd);
      check($sformatf("rand_irq_%0d", n), {31'd0, bus.irq}, {31'd0, |(m_cap & m_mask)});
    end
    bus_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
